// File: rtl/t07_button_pkg.sv
// t07_button_pkg: shared definitions for the button event detector.
// Holds the one-hot key codes of the standard six-button pad and the
// per-channel hold/repeat state encoding.
package t07_button_pkg;

    localparam logic [5:0] NO_PRESS = 6'b000000;
    localparam logic [5:0] SELECT   = 6'b000001;
    localparam logic [5:0] UP       = 6'b000010;
    localparam logic [5:0] RIGHT    = 6'b000100;
    localparam logic [5:0] DOWN     = 6'b001000;
    localparam logic [5:0] LEFT     = 6'b010000;
    localparam logic [5:0] BACK     = 6'b100000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

endpackage

// File: rtl/t07_button_channel.sv
// t07_button_channel: one button lane. Synchronises the raw level,
// debounces it, emits single-cycle press/release pulses and runs the
// hold-to-repeat state machine that produces auto-repeat pulses.
module t07_button_channel
    import t07_button_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 10,
    parameter int EN_REPEAT     = 1
) (
    input  logic clk,
    input  logic nrst,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic repeat_o
);

    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES);

    logic          sync_meta;
    logic          sync_s;
    logic [DW-1:0] db_cnt;
    logic          level_d;
    logic          level_up;
    btn_state_t    state;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;

    // Two-flop synchroniser bringing the asynchronous button into clk.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
        end else begin
            sync_meta <= in_i;
            sync_s    <= sync_meta;
        end
    end

    // Debounce: the level only follows the input after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            db_cnt  <= '0;
            level_o <= 1'b0;
        end else if (sync_s == level_o) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level_o <= sync_s;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end

    assign level_up = level_o & ~level_d;

    // Edge detection on the debounced level gives one-cycle press/release pulses.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            level_d <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            level_d <= level_o;
            rise_o  <= level_up;
            fall_o  <= ~level_o & level_d;
        end
    end

    // Hold/repeat FSM: counts from the press pulse, fires while the level stays high, aborts on release.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            repeat_o <= 1'b0;
        end else begin
            repeat_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (level_up) begin
                        state    <= HOLD;
                        hold_cnt <= HW'(1);
                    end
                end
                HOLD: begin
                    if (!level_o) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= REPEAT;
                        hold_cnt <= '0;
                        rep_cnt  <= RW'(1);
                        repeat_o <= (EN_REPEAT != 0);
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                REPEAT: begin
                    if (!level_o) begin
                        state   <= IDLE;
                        rep_cnt <= '0;
                    end else if (rep_cnt == REPEAT_LAST) begin
                        rep_cnt  <= RW'(1);
                        repeat_o <= (EN_REPEAT != 0);
                    end else begin
                        rep_cnt <= rep_cnt + RW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                    rep_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/t07_button_event_detector.sv
// t07_button_event_detector: N_CH independent button lanes plus a
// lowest-index-wins encoder that turns the merged press/repeat events
// into a one-hot key code and a valid flag.
module t07_button_event_detector
    import t07_button_pkg::*;
#(
    parameter int N_CH          = 6,
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 10,
    parameter int EN_REPEAT     = 1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [N_CH-1:0] in_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] repeat_o,
    output logic [N_CH-1:0] event_o,
    output logic [N_CH-1:0] code_o,
    output logic            valid_o
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        t07_button_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .EN_REPEAT     (EN_REPEAT)
        ) u_channel (
            .clk      (clk),
            .nrst     (nrst),
            .in_i     (in_i[g]),
            .level_o  (level_o[g]),
            .rise_o   (rise_o[g]),
            .fall_o   (fall_o[g]),
            .repeat_o (repeat_o[g])
        );
    end

    assign event_o = rise_o | repeat_o;

    // Lowest set bit isolated by the two's-complement trick; other simultaneous events are dropped.
    always_comb begin
        code_o  = event_o & (~event_o + N_CH'(1));
        valid_o = |event_o;
    end

endmodule

// File: tb/tb_t07_button_event_detector.sv
// tb_t07_button_event_detector: randomised and directed stimulus for two
// detector instances (auto-repeat on and off) checked every cycle against
// a history-window reference model of the button behaviour.
module tb_t07_button_event_detector;
    import t07_button_pkg::*;

    localparam int N    = 6;
    localparam int DB   = 4;
    localparam int HOLD = 50;
    localparam int REP  = 10;
    localparam int MAXE = 8000;

    logic         clk  = 1'b0;
    logic         nrst = 1'b0;
    logic [N-1:0] in_i = '0;

    logic [N-1:0] level_a, rise_a, fall_a, rep_a, ev_a, code_a;
    logic         valid_a;
    logic [N-1:0] level_b, rise_b, fall_b, rep_b, ev_b, code_b;
    logic         valid_b;

    int tests    = 0;
    int failures = 0;
    int edge_no  = 1;
    int last_rst = 0;

    logic [N-1:0] in_hist  [MAXE];
    logic [N-1:0] lvl_hist [MAXE];
    int           rise_edge [N];
    logic [N-1:0] exp_level, exp_rise, exp_fall, exp_rep;

    int           cnt_rise_a [N];
    int           cnt_fall_a [N];
    int           cnt_rep_a  [N];
    int           cnt_rise_b [N];
    int           cnt_rep_b  [N];
    int           first_level_a [N];
    int           first_rise_a  [N];
    int           first_rep_a   [N];
    int           last_rep_a    [N];
    logic [N-1:0] ev_at_rise    [N];
    logic [N-1:0] code_at_rise  [N];
    logic         valid_at_rise [N];
    logic [N-1:0] activity_a;

    always #5 clk = ~clk;

    t07_button_event_detector #(
        .N_CH(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .EN_REPEAT(1)
    ) dut_a (
        .clk(clk), .nrst(nrst), .in_i(in_i),
        .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a), .repeat_o(rep_a),
        .event_o(ev_a), .code_o(code_a), .valid_o(valid_a)
    );

    t07_button_event_detector #(
        .N_CH(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .EN_REPEAT(0)
    ) dut_b (
        .clk(clk), .nrst(nrst), .in_i(in_i),
        .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b), .repeat_o(rep_b),
        .event_o(ev_b), .code_o(code_b), .valid_o(valid_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, edge_no, got, exp);
        end
    endtask

    function automatic logic [N-1:0] lowestOne(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = N'(1) << i;
        end
        return r;
    endfunction

    // Level flips once the last DB post-reset samples all disagree with it;
    // repeats fall on HOLD + m*REP edges after the press while still held.
    task automatic modelStep(input logic rst_low, input logic [N-1:0] inv);
        int   e;
        logic prev, flip;
        e = edge_no;
        if (rst_low) begin
            last_rst      = e;
            in_hist[e]    = '0;
            in_hist[e-1]  = '0;
            lvl_hist[e]   = '0;
            lvl_hist[e-1] = '0;
            exp_level = '0;
            exp_rise  = '0;
            exp_fall  = '0;
            exp_rep   = '0;
            for (int c = 0; c < N; c++) rise_edge[c] = -1;
        end else begin
            in_hist[e] = inv;
            for (int c = 0; c < N; c++) begin
                prev = lvl_hist[e-1][c];
                flip = (e - DB + 1 > last_rst);
                if (flip) begin
                    for (int k = 0; k < DB; k++) begin
                        if (in_hist[e-2-k][c] == prev) flip = 1'b0;
                    end
                end
                lvl_hist[e][c] = prev ^ flip;
                exp_level[c]   = prev ^ flip;
                exp_rise[c]    = lvl_hist[e-1][c] & ~lvl_hist[e-2][c];
                exp_fall[c]    = ~lvl_hist[e-1][c] & lvl_hist[e-2][c];
                if (exp_rise[c]) rise_edge[c] = e;
                exp_rep[c] = (rise_edge[c] >= 0) && lvl_hist[e-1][c] &&
                             ((e - rise_edge[c]) >= HOLD) &&
                             (((e - rise_edge[c] - HOLD) % REP) == 0);
            end
        end
    endtask

    task automatic compareAll();
        logic [N-1:0] exp_ev_a, exp_ev_b;
        exp_ev_a = exp_rise | exp_rep;
        exp_ev_b = exp_rise;
        checkOutput("level_a",  64'(level_a), 64'(exp_level));
        checkOutput("rise_a",   64'(rise_a),  64'(exp_rise));
        checkOutput("fall_a",   64'(fall_a),  64'(exp_fall));
        checkOutput("repeat_a", 64'(rep_a),   64'(exp_rep));
        checkOutput("event_a",  64'(ev_a),    64'(exp_ev_a));
        checkOutput("code_a",   64'(code_a),  64'(lowestOne(exp_ev_a)));
        checkOutput("valid_a",  64'(valid_a), 64'(|exp_ev_a));
        checkOutput("level_b",  64'(level_b), 64'(exp_level));
        checkOutput("rise_b",   64'(rise_b),  64'(exp_rise));
        checkOutput("fall_b",   64'(fall_b),  64'(exp_fall));
        checkOutput("repeat_b", 64'(rep_b),   64'(0));
        checkOutput("event_b",  64'(ev_b),    64'(exp_ev_b));
        checkOutput("code_b",   64'(code_b),  64'(lowestOne(exp_ev_b)));
        checkOutput("valid_b",  64'(valid_b), 64'(|exp_ev_b));
    endtask

    task automatic clearMonitors();
        for (int c = 0; c < N; c++) begin
            cnt_rise_a[c]    = 0;
            cnt_fall_a[c]    = 0;
            cnt_rep_a[c]     = 0;
            cnt_rise_b[c]    = 0;
            cnt_rep_b[c]     = 0;
            first_level_a[c] = -1;
            first_rise_a[c]  = -1;
            first_rep_a[c]   = -1;
            last_rep_a[c]    = -1;
            ev_at_rise[c]    = '0;
            code_at_rise[c]  = '0;
            valid_at_rise[c] = 1'b0;
        end
        activity_a = '0;
    endtask

    task automatic updateMonitors();
        for (int c = 0; c < N; c++) begin
            if (level_a[c] && first_level_a[c] < 0) first_level_a[c] = edge_no;
            if (rise_a[c]) begin
                cnt_rise_a[c]++;
                if (first_rise_a[c] < 0) begin
                    first_rise_a[c]  = edge_no;
                    ev_at_rise[c]    = ev_a;
                    code_at_rise[c]  = code_a;
                    valid_at_rise[c] = valid_a;
                end
            end
            if (fall_a[c]) cnt_fall_a[c]++;
            if (rep_a[c]) begin
                cnt_rep_a[c]++;
                if (first_rep_a[c] < 0) first_rep_a[c] = edge_no;
                last_rep_a[c] = edge_no;
            end
            if (rise_b[c]) cnt_rise_b[c]++;
            if (rep_b[c]) cnt_rep_b[c]++;
            if (level_a[c] | rise_a[c] | fall_a[c] | rep_a[c] | ev_a[c]) activity_a[c] = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] inv, input logic rst_n_v);
        @(negedge clk);
        in_i = inv;
        nrst = rst_n_v;
        @(posedge clk);
        edge_no++;
        modelStep(!rst_n_v, inv);
        #1;
        compareAll();
        updateMonitors();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_a"}, 64'({level_a, rise_a, fall_a, rep_a, ev_a, code_a, valid_a}), 64'(0));
        checkOutput({tag, "_b"}, 64'({level_b, rise_b, fall_b, rep_b, ev_b, code_b, valid_b}), 64'(0));
    endtask

    initial begin
        logic [N-1:0] v;
        int           k;
        int           prob [N];

        in_hist[0]  = '0;
        in_hist[1]  = '0;
        lvl_hist[0] = '0;
        lvl_hist[1] = '0;
        for (int c = 0; c < N; c++) rise_edge[c] = -1;
        clearMonitors();

        repeat (3) applyStimulus('0, 1'b0);
        checkAllZero("reset_outs");
        applyStimulus('0, 1'b1);
        checkAllZero("first_after_reset");
        repeat (4) applyStimulus('0, 1'b1);

        // Single press on channel 0: latency and code.
        clearMonitors();
        k = edge_no + 1;
        repeat (20) applyStimulus(6'b000001, 1'b1);
        repeat (20) applyStimulus('0, 1'b1);
        checkOutput("p1_level_latency", 64'(first_level_a[0] - k), 64'(DB + 1));
        checkOutput("p1_rise_latency",  64'(first_rise_a[0] - k),  64'(DB + 2));
        checkOutput("p1_rise_count",    64'(cnt_rise_a[0]),        64'(1));
        checkOutput("p1_fall_count",    64'(cnt_fall_a[0]),        64'(1));
        checkOutput("p1_code",          64'(code_at_rise[0]),      64'(SELECT));
        checkOutput("p1_valid",         64'(valid_at_rise[0]),     64'(1));

        // Three-cycle glitch on channel 2 must be filtered out.
        clearMonitors();
        repeat (3) applyStimulus(6'b000100, 1'b1);
        repeat (12) applyStimulus('0, 1'b1);
        checkOutput("p2_glitch_activity", 64'(activity_a[2]), 64'(0));

        // Channel 1 held 100 cycles: repeats at +50,+60..+90, release suppresses the +100 one.
        clearMonitors();
        repeat (100) applyStimulus(6'b000010, 1'b1);
        repeat (30) applyStimulus('0, 1'b1);
        checkOutput("p3_rise_count",   64'(cnt_rise_a[1]),                  64'(1));
        checkOutput("p3_repeat_count", 64'(cnt_rep_a[1]),                   64'(5));
        checkOutput("p3_first_repeat", 64'(first_rep_a[1] - first_rise_a[1]), 64'(HOLD));
        checkOutput("p3_repeat_span",  64'(last_rep_a[1] - first_rep_a[1]),  64'(4 * REP));
        checkOutput("p3_fall_count",   64'(cnt_fall_a[1]),                  64'(1));
        checkOutput("p3_repeat_b",     64'(cnt_rep_b[1]),                   64'(0));

        // Channels 3 and 5 together: lowest index wins the code.
        clearMonitors();
        repeat (15) applyStimulus(6'b101000, 1'b1);
        repeat (15) applyStimulus('0, 1'b1);
        checkOutput("p4_rise3",      64'(cnt_rise_a[3]),   64'(1));
        checkOutput("p4_rise5",      64'(cnt_rise_a[5]),   64'(1));
        checkOutput("p4_same_cycle", 64'(first_rise_a[5] - first_rise_a[3]), 64'(0));
        checkOutput("p4_event",      64'(ev_at_rise[3]),   64'(6'b101000));
        checkOutput("p4_code",       64'(code_at_rise[3]), 64'(DOWN));
        checkOutput("p4_valid",      64'(valid_at_rise[3]), 64'(1));

        // Channel 4 in auto-repeat, reset for two cycles while still held.
        clearMonitors();
        repeat (70) applyStimulus(6'b010000, 1'b1);
        checkOutput("p5_repeats_before_reset", 64'(cnt_rep_a[4]), 64'(2));
        for (int i = 0; i < 2; i++) begin
            applyStimulus(6'b010000, 1'b0);
            checkAllZero("p5_reset_outs");
        end
        clearMonitors();
        k = edge_no + 1;
        applyStimulus(6'b010000, 1'b1);
        checkAllZero("p5_first_after_release");
        repeat (19) applyStimulus(6'b010000, 1'b1);
        checkOutput("p5_rise_latency", 64'(first_rise_a[4] - k), 64'(DB + 2));
        checkOutput("p5_rise_count",   64'(cnt_rise_a[4]),       64'(1));
        checkOutput("p5_fall_count",   64'(cnt_fall_a[4]),       64'(0));
        repeat (20) applyStimulus('0, 1'b1);

        // Long 200-cycle hold: repeat-disabled instance must stay silent.
        clearMonitors();
        repeat (200) applyStimulus(6'b000001, 1'b1);
        repeat (20) applyStimulus('0, 1'b1);
        checkOutput("p6_rise_b",   64'(cnt_rise_b[0]), 64'(1));
        checkOutput("p6_repeat_b", 64'(cnt_rep_b[0]),  64'(0));
        checkOutput("p6_repeat_a", 64'(cnt_rep_a[0]),  64'(15));

        // Random traffic with mixed bounce rates and occasional resets.
        v = '0;
        for (int seg = 0; seg < 25; seg++) begin
            for (int c = 0; c < N; c++) begin
                case ($urandom_range(0, 3))
                    0:       prob[c] = 0;
                    1:       prob[c] = 2;
                    2:       prob[c] = 15;
                    default: prob[c] = 45;
                endcase
            end
            for (int t = 0; t < 80; t++) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(0, 99) < prob[c]) v[c] = ~v[c];
                end
                applyStimulus(v, ($urandom_range(0, 299) != 0));
            end
        end
        repeat (20) applyStimulus('0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
